// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters; IDLE->EXEC->RESP, one op per 3 cycles.
// Optional ALU_ARB_PERF_EN adds a 16-bit wrapping op_count of completed responses.
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_overflow,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_overflow,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]       op_count,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   last_grant;
  logic   gnt0, gnt1;
  logic   accept;
  logic   rsp_done;

  // On contention the requester that did not win last time is favoured.
  assign gnt0 = req0_valid & (~req1_valid | last_grant);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant);

  assign accept   = (state == IDLE) & (gnt0 | gnt1);
  assign rsp_done = (state == RESP) & (owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt0 | gnt1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) & gnt0;
    req1_ready = (state == IDLE) & gnt1;
    rsp0_valid = (state == RESP) & ~owner;
    rsp1_valid = (state == RESP) & owner;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= 2'b00;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        alu_a    <= gnt0 ? req0_a  : req1_a;
        alu_b    <= gnt0 ? req0_b  : req1_b;
        alu_ctrl <= gnt0 ? req0_op : req1_op;
        owner    <= gnt1;
      end
      if (rsp_done) last_grant <= owner;
    end
  end

  // Response registers are per port so each requester sees only its own data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_result   <= '0;
      rsp0_zero     <= 1'b0;
      rsp0_overflow <= 1'b0;
      rsp1_result   <= '0;
      rsp1_zero     <= 1'b0;
      rsp1_overflow <= 1'b0;
    end else if (state == EXEC) begin
      if (owner) begin
        rsp1_result   <= alu_result;
        rsp1_zero     <= alu_zero;
        rsp1_overflow <= alu_overflow;
      end else begin
        rsp0_result   <= alu_result;
        rsp0_zero     <= alu_zero;
        rsp0_overflow <= alu_overflow;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [15:0] op_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        op_cnt <= 16'h0000;
    else if (rsp_done) op_cnt <= op_cnt + 16'h0001;
  end

  assign op_count = op_cnt;
`endif

endmodule
